// File: rtl/sram_read_sequencer.sv
// SRAM row-read sequencer.
//
// Steps one row read through precharge, bitline develop and sense, then holds
// the resolved word until the consumer takes it.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   rd_req        read request, accepted when rd_ready=1
//   rd_addr       row address, latched on acceptance
//   rd_ready      sequencer idle, request accepted this cycle
//   precharge_en  bitline precharge drive
//   wl_en         wordline enable for row wl_addr
//   wl_addr       latched row address
//   sense_en      sense-amplifier enable
//   bl / bln      sensed true / complement bitline levels
//   rd_data       resolved read word
//   rd_err        at least one bitline pair was non-complementary at sense
//   rd_valid      rd_data/rd_err valid, held until rd_taken
//   rd_taken      consumer accepts the word while rd_valid=1
module sram_read_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEV_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              precharge_en,
    output logic              wl_en,
    output logic [ADDR_W-1:0] wl_addr,
    output logic              sense_en,
    input  logic [DATA_W-1:0] bl,
    input  logic [DATA_W-1:0] bln,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              rd_valid,
    input  logic              rd_taken
);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StDev,
        StSense,
        StHold
    } state_t;

    localparam logic [3:0] DevLoad = 4'(DEV_CYCLES);

    state_t     state;
    logic [3:0] dev_cnt;

    // All outputs are registered and set together with the state they belong
    // to, so the wordline never overlaps precharge and no input reaches an
    // output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            dev_cnt      <= '0;
            wl_addr      <= '0;
            rd_data      <= '0;
            rd_err       <= 1'b0;
            rd_ready     <= 1'b1;
            precharge_en <= 1'b1;
            wl_en        <= 1'b0;
            sense_en     <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (rd_req) begin
                        state    <= StPre;
                        wl_addr  <= rd_addr;
                        rd_ready <= 1'b0;
                    end
                end
                StPre: begin
                    state        <= StDev;
                    dev_cnt      <= DevLoad;
                    precharge_en <= 1'b0;
                    wl_en        <= 1'b1;
                end
                StDev: begin
                    // Counter holds the DEV cycles still to run, this one included.
                    if (dev_cnt == 4'd1) begin
                        state    <= StSense;
                        dev_cnt  <= '0;
                        sense_en <= 1'b1;
                    end else begin
                        dev_cnt <= dev_cnt - 4'd1;
                    end
                end
                StSense: begin
                    state        <= StHold;
                    // A bit reads 1 only for bl=1/bln=0; equal levels flag an error.
                    rd_data      <= bl & ~bln;
                    rd_err       <= ~&(bl ^ bln);
                    wl_en        <= 1'b0;
                    sense_en     <= 1'b0;
                    precharge_en <= 1'b1;
                    rd_valid     <= 1'b1;
                end
                StHold: begin
                    if (rd_taken) begin
                        state    <= StIdle;
                        rd_valid <= 1'b0;
                        rd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Bench for sram_read_sequencer: three instances (DEV_CYCLES 2, 1, 15), each
// with randomized reads, a scoreboard queue filled at request time and a
// monitor that pops and compares whenever rd_valid rises.
`timescale 1ns/1ps
module tb_sram_read_sequencer;

    localparam int NTX = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done [3];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } exp_t;

    function automatic void chk(input int dev, input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL dev=%0d %s: got 0x%0h, required 0x%0h", dev, name, act, req);
        end
    endfunction

    // Reference: resolve each bitline pair independently.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        exp_t e;
        e.addr = a;
        e.data = 8'h00;
        e.err  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b[i] == 1'b1 && n[i] == 1'b0) e.data[i] = 1'b1;
            else if (!(b[i] == 1'b0 && n[i] == 1'b1)) e.err = 1'b1;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DEV = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        localparam int          D   = int'(DEV);

        logic       rst, rd_req, rd_ready, precharge_en, wl_en, sense_en;
        logic       rd_err, rd_valid, rd_taken;
        logic [7:0] rd_addr, wl_addr, bl, bln, rd_data;
        logic [7:0] sense_bl, sense_bln;
        exp_t       sb [$];

        int   mon_n  = 0;
        int   acc_n  = -1;
        int   wl_cnt = 0;
        bit   pv     = 1'b0;
        bit   pw     = 1'b0;
        exp_t cur;

        sram_read_sequencer #(
            .ADDR_W    (8),
            .DATA_W    (8),
            .DEV_CYCLES(DEV)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .rd_req      (rd_req),
            .rd_addr     (rd_addr),
            .rd_ready    (rd_ready),
            .precharge_en(precharge_en),
            .wl_en       (wl_en),
            .wl_addr     (wl_addr),
            .sense_en    (sense_en),
            .bl          (bl),
            .bln         (bln),
            .rd_data     (rd_data),
            .rd_err      (rd_err),
            .rd_valid    (rd_valid),
            .rd_taken    (rd_taken)
        );

        // Array model: real levels only while sensing, noise otherwise.
        always @(negedge clk) begin
            if (sense_en) begin
                bl  = sense_bl;
                bln = sense_bln;
            end else begin
                bl  = 8'($urandom);
                bln = 8'($urandom);
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                assert (!(wl_en && precharge_en))
                else $error("dev=%0d wordline and precharge both on", D);
            end
        end

        task automatic chk_reset(input string tag);
            chk(D, {tag, "_rd_ready"}, int'(rd_ready), 1);
            chk(D, {tag, "_precharge_en"}, int'(precharge_en), 1);
            chk(D, {tag, "_wl_en"}, int'(wl_en), 0);
            chk(D, {tag, "_sense_en"}, int'(sense_en), 0);
            chk(D, {tag, "_rd_valid"}, int'(rd_valid), 0);
            chk(D, {tag, "_rd_err"}, int'(rd_err), 0);
            chk(D, {tag, "_rd_data"}, int'(rd_data), 0);
            chk(D, {tag, "_wl_addr"}, int'(wl_addr), 0);
        endtask

        task automatic issue(input int t);
            logic [7:0] a, b, n;
            a = 8'($urandom);
            b = 8'($urandom);
            n = ~b;
            if ($urandom_range(0, 3) == 0) n = n ^ (8'd1 << $urandom_range(0, 7));
            if (t == 0) begin
                a = 8'h3A;
                b = 8'hA5;
                n = 8'h5A;
            end else if (t == 1) begin
                b = 8'hFF;
                n = 8'h01;
            end
            rd_addr   = a;
            sense_bl  = b;
            sense_bln = n;
            rd_req    = 1'b1;
            sb.push_back(model(a, b, n));
        endtask

        // Monitor: samples 1 ns after the falling edge.
        initial begin
            cur = '0;
            forever begin
                @(negedge clk);
                #1;
                mon_n++;
                if (rst) begin
                    acc_n  = -1;
                    wl_cnt = 0;
                    pv     = 1'b0;
                    pw     = 1'b0;
                end else begin
                    chk(D, "wl_pre_overlap", int'(wl_en & precharge_en), 0);
                    if (rd_ready) chk(D, "idle_precharge", int'(precharge_en), 1);
                    if (wl_en) begin
                        wl_cnt++;
                    end else if (pw) begin
                        chk(D, "wl_en_cycles", wl_cnt, D + 1);
                        wl_cnt = 0;
                    end
                    if (rd_valid && !pv) begin
                        if (sb.size() == 0) begin
                            chk(D, "unexpected_rd_valid", 1, 0);
                        end else begin
                            cur = sb.pop_front();
                            chk(D, "rd_data", int'(rd_data), int'(cur.data));
                            chk(D, "rd_err", int'(rd_err), int'(cur.err));
                            chk(D, "wl_addr", int'(wl_addr), int'(cur.addr));
                            if (acc_n < 0) chk(D, "accept_seen", 0, 1);
                            else chk(D, "latency", mon_n - acc_n - 1, D + 2);
                        end
                    end else if (rd_valid) begin
                        chk(D, "hold_rd_data", int'(rd_data), int'(cur.data));
                        chk(D, "hold_rd_err", int'(rd_err), int'(cur.err));
                        chk(D, "hold_wl_addr", int'(wl_addr), int'(cur.addr));
                        chk(D, "hold_precharge", int'(precharge_en), 1);
                    end
                    if (rd_ready && rd_req) acc_n = mon_n;
                    pv = rd_valid;
                    pw = wl_en;
                end
            end
        end

        // Stimulus.
        initial begin
            int k;
            int hold;
            bit pre;
            rst       = 1'b1;
            rd_req    = 1'b0;
            rd_addr   = 8'h00;
            rd_taken  = 1'b0;
            sense_bl  = 8'h00;
            sense_bln = 8'h00;
            pre       = 1'b0;
            repeat (3) @(negedge clk);
            chk_reset("por");
            rst = 1'b0;
            for (int t = 0; t < NTX; t++) begin
                if (!pre) begin
                    k = 0;
                    while (!rd_ready && k < 50) begin
                        @(negedge clk);
                        k++;
                    end
                    chk(D, "rd_ready_wait", int'(rd_ready), 1);
                    issue(t);
                end
                pre = 1'b0;
                @(negedge clk);
                rd_req = 1'b0;
                if (t == 4) begin
                    // Asynchronous reset in the middle of the develop phase.
                    k = 0;
                    while (!wl_en && k < 10) begin
                        @(negedge clk);
                        k++;
                    end
                    chk(D, "reached_dev", int'(wl_en), 1);
                    #3 rst = 1'b1;
                    #1;
                    chk_reset("mid_dev");
                    sb.delete();
                    @(negedge clk);
                    #3 rst = 1'b0;
                    @(negedge clk);
                    continue;
                end
                k = 0;
                while (!rd_valid && k < 40) begin
                    rd_taken = 1'($urandom);
                    @(negedge clk);
                    k++;
                end
                rd_taken = 1'b0;
                chk(D, "rd_valid_wait", int'(rd_valid), 1);
                hold = (t == 2) ? 10 : int'($urandom_range(0, 3));
                for (int h = 0; h < hold; h++) begin
                    rd_req  = 1'($urandom);
                    rd_addr = 8'($urandom);
                    @(negedge clk);
                end
                rd_taken = 1'b1;
                rd_req   = 1'b0;
                if ((t % 3 == 1) && (t + 1 < NTX) && (t + 1 != 4)) begin
                    issue(t + 1);
                    pre = 1'b1;
                end
                @(negedge clk);
                rd_taken = 1'b0;
                if (pre) chk(D, "b2b_rd_ready", int'(rd_ready), 1);
            end
            repeat (3) @(negedge clk);
            chk(D, "scoreboard_drained", sb.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(done[0] && done[1] && done[2]) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (!(done[0] && done[1] && done[2])) chk(-1, "run_complete", 0, 1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
